// File: rtl/tap_accumulate_clamp_pkg.sv
// Shared upscaler definitions used by the multiplier, this accumulator and the
// line writer. Pixel geometry, product width, the weight fixed-point scale and
// the rounding constant used when dropping the fractional weight bits.
package tap_accumulate_clamp_pkg;

    localparam int PIX_W     = 8;
    localparam int PIX_MAX   = 255;
    localparam int PROD_W    = 20;
    localparam int FRAC_BITS = 7;

    // Half an LSB of the rescaled result; added before the arithmetic shift
    // so that exact ties round toward +infinity.
    localparam int ROUND_HALF  = 1 << (FRAC_BITS - 1);
    localparam int ROUND_SHIFT = FRAC_BITS;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    function automatic int round_half(input int frac_bits);
        return 1 << (frac_bits - 1);
    endfunction

endpackage

// File: rtl/tap_accumulate_clamp_round_clamp.sv
// round_clamp: purely combinational back end of the tap accumulator.
// Adds half an LSB, arithmetic-shifts out FRAC_BITS and clamps the signed
// result into an unsigned pixel.
// Ports:
//   total  in   ACC_W   signed accumulated sum of all taps of one pixel
//   pixel  out  PIX_W   rounded, clamped unsigned pixel
//   sat    out  1       result was outside [0, PIX_MAX] and got clamped
module round_clamp #(
    parameter int ACC_W     = 24,
    parameter int FRAC_BITS = tap_accumulate_clamp_pkg::FRAC_BITS
) (
    input  logic signed [ACC_W-1:0]                          total,
    output logic        [tap_accumulate_clamp_pkg::PIX_W-1:0] pixel,
    output logic                                              sat
);
    import tap_accumulate_clamp_pkg::*;

    // One guard bit so adding the rounding constant can never wrap.
    localparam int RND_W = ACC_W + 1;
    localparam logic signed [RND_W-1:0] ROUND_K = RND_W'(round_half(FRAC_BITS));

    logic signed [RND_W-1:0] biased;
    logic signed [RND_W-1:0] r;
    logic                    neg;
    logic                    over;

    always_comb begin
        biased = {total[ACC_W-1], total} + ROUND_K;
        r      = biased >>> FRAC_BITS;
        neg    = r[RND_W-1];
        // Any set bit above the pixel field on a non-negative value means > PIX_MAX.
        over   = !neg && (r[RND_W-2:PIX_W] != '0);
        sat    = neg | over;
        if (neg) begin
            pixel = '0;
        end else if (over) begin
            pixel = PIX_W'(PIX_MAX);
        end else begin
            pixel = r[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/tap_accumulate_clamp.sv
// tap_accumulate_clamp: sums NUM_TAPS signed products into one output pixel,
// rounds/rescales through round_clamp and presents the pixel on a
// valid/ready output register. The next group keeps accumulating while the
// output is stalled; only its last tap is held off.
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous active-high reset
//   in_valid   in   1       in_prod valid
//   in_ready   out  1       product accepted this cycle when in_valid
//   in_prod    in   PROD_W  signed product
//   out_valid  out  1       out_pixel/out_sat hold a finished pixel
//   out_ready  in   1       consumer takes the pixel
//   out_pixel  out  8       rounded, clamped pixel
//   out_sat    out  1       pixel was clamped
//   sat_count  out  16      (only with SAT_COUNT_EN) saturating count of
//                           handshaked pixels that were clamped
// Build option: define SAT_COUNT_EN to add the sat_count port and counter.
//
// Output-side state (tap phase ACCUM/LAST is tap_cnt < or == NUM_TAPS-1):
//   state     | meaning
//   OUT_EMPTY | no pixel held, out_valid low
//   OUT_FULL  | pixel held until popped or replaced by a new last tap
module tap_accumulate_clamp #(
    parameter int NUM_TAPS  = 4,
    parameter int PROD_W    = tap_accumulate_clamp_pkg::PROD_W,
    parameter int ACC_W     = 24,
    parameter int FRAC_BITS = tap_accumulate_clamp_pkg::FRAC_BITS
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [PROD_W-1:0]                           in_prod,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [tap_accumulate_clamp_pkg::PIX_W-1:0]  out_pixel,
    output logic                                        out_sat
`ifdef SAT_COUNT_EN
    ,
    output logic [15:0]                                 sat_count
`endif
);
    import tap_accumulate_clamp_pkg::*;

    localparam int TAP_W = $clog2(NUM_TAPS);
    localparam logic [TAP_W-1:0] LAST_IDX = TAP_W'(NUM_TAPS - 1);

    logic [ACC_W-1:0] acc;
    logic [TAP_W-1:0] tap_cnt;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] total;
    logic             last_tap;
    logic             accept;
    logic             load;
    logic             pop;
    logic [PIX_W-1:0] rc_pixel;
    logic             rc_sat;

    out_state_t out_state;
    out_state_t out_state_nxt;

    assign prod_ext  = {{(ACC_W - PROD_W){in_prod[PROD_W-1]}}, in_prod};
    assign total     = acc + prod_ext;
    assign last_tap  = (tap_cnt == LAST_IDX);
    assign out_valid = (out_state == OUT_FULL);
    // Only the final tap needs a free output slot; a pop in the same cycle frees it.
    assign in_ready  = !(last_tap && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign load      = accept && last_tap;
    assign pop       = out_valid && out_ready;

    round_clamp #(
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_clamp (
        .total (total),
        .pixel (rc_pixel),
        .sat   (rc_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state <= OUT_EMPTY;
        end else begin
            out_state <= out_state_nxt;
        end
    end

    always_comb begin
        out_state_nxt = out_state;
        case (out_state)
            OUT_EMPTY: begin
                if (load) begin
                    out_state_nxt = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (pop && !load) begin
                    out_state_nxt = OUT_EMPTY;
                end
            end
            default: out_state_nxt = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            tap_cnt <= '0;
        end else if (accept) begin
            if (last_tap) begin
                acc     <= '0;
                tap_cnt <= '0;
            end else begin
                acc     <= total;
                tap_cnt <= tap_cnt + 1'b1;
            end
        end
    end

    // Data only changes on a load, so it is stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pixel <= '0;
            out_sat   <= 1'b0;
        end else if (load) begin
            out_pixel <= rc_pixel;
            out_sat   <= rc_sat;
        end
    end

`ifdef SAT_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (pop && out_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule
